// File: rtl/norm_shift_if.sv
// Handshake bundle for the leading-zero normalizer: input word stream in,
// MSB-aligned word plus shift amount and zero flag out.
interface norm_shift_if #(parameter int LENGTH = 8);
  localparam int SW = $clog2(LENGTH);

  logic              in_valid;
  logic              in_ready;
  logic [LENGTH-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [LENGTH-1:0] out_data;
  logic [SW-1:0]     out_shamt;
  logic              out_zero;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_shamt, out_zero
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_shamt, out_zero
  );
endinterface

// File: rtl/norm_shift.sv
// Two-stage leading-zero normalizer: S1 registers word + lzc, a log-stage
// barrel shifter aligns it, S2 holds the MSB-aligned result.
module BarrelShift #(
  parameter int LENGTH = 8,
  parameter bit LEFT   = 1
) (
  input  logic [LENGTH-1:0]         data_in,
  input  logic [$clog2(LENGTH)-1:0] shamt,
  output logic [LENGTH-1:0]         data_out
);
  localparam int SW = $clog2(LENGTH);

  logic [SW:0][LENGTH-1:0] stage;

  assign stage[0] = data_in;

  // Stage i shifts by 2**i when shamt[i] is set; vacated bits fill with zero.
  for (genvar i = 0; i < SW; i++) begin : g_stage
    if (LEFT) begin : g_left
      assign stage[i+1] = shamt[i] ? (stage[i] << (1 << i)) : stage[i];
    end else begin : g_right
      assign stage[i+1] = shamt[i] ? (stage[i] >> (1 << i)) : stage[i];
    end
  end

  assign data_out = stage[SW];
endmodule

module norm_shift #(
  parameter int LENGTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  norm_shift_if.slave  bus
);
  localparam int SW     = $clog2(LENGTH);
  localparam int STAGES = 2;

  logic [STAGES:1]   vld_pipe;
  logic [LENGTH-1:0] s1_data;
  logic [SW-1:0]     s1_lzc;
  logic              s1_zero;
  logic [LENGTH-1:0] shifted;
  logic [SW-1:0]     lzc;
  logic [LENGTH-1:0] out_data_q;
  logic [SW-1:0]     out_shamt_q;
  logic              out_zero_q;
  logic              s2_free, s1_adv, in_fire;

  assign s2_free      = !vld_pipe[2] || bus.out_ready;
  assign s1_adv       = vld_pipe[1] && s2_free;
  assign bus.in_ready = !vld_pipe[1] || s2_free;
  assign in_fire      = bus.in_valid && bus.in_ready;

  // Scan upward so the highest set bit writes last; a zero word keeps lzc = 0.
  always_comb begin
    lzc = '0;
    for (int i = 0; i < LENGTH; i++)
      if (bus.in_data[i]) lzc = SW'(LENGTH - 1 - i);
  end

  BarrelShift #(LENGTH, 1) u_shift (
    .data_in  (s1_data),
    .shamt    (s1_lzc),
    .data_out (shifted)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe    <= '0;
      s1_data     <= '0;
      s1_lzc      <= '0;
      s1_zero     <= 1'b0;
      out_data_q  <= '0;
      out_shamt_q <= '0;
      out_zero_q  <= 1'b0;
    end else begin
      if (in_fire) begin
        vld_pipe[1] <= 1'b1;
        s1_data     <= bus.in_data;
        s1_lzc      <= lzc;
        s1_zero     <= ~|bus.in_data;
      end else if (s1_adv) begin
        vld_pipe[1] <= 1'b0;
      end
      // Output fields only move on an advance, so a stalled word stays put.
      if (s2_free) vld_pipe[2] <= vld_pipe[1];
      if (s1_adv) begin
        out_data_q  <= shifted;
        out_shamt_q <= s1_lzc;
        out_zero_q  <= s1_zero;
      end
    end
  end

  assign bus.out_valid = vld_pipe[2];
  assign bus.out_data  = out_data_q;
  assign bus.out_shamt = out_shamt_q;
  assign bus.out_zero  = out_zero_q;
endmodule

// File: tb/tb_norm_shift.sv
// Scoreboard bench for norm_shift at LENGTH = 8 and LENGTH = 16.
module tb_norm_shift;
  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  shamt;
    logic        zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass = 0;
  int   total = 0;
  exp_t q8[$];
  exp_t q16[$];

  always #5 clk = ~clk;

  norm_shift_if #(.LENGTH(8))  a();
  norm_shift_if #(.LENGTH(16)) b();

  norm_shift #(.LENGTH(8))  u8  (.clk(clk), .rst(rst), .bus(a.slave));
  norm_shift #(.LENGTH(16)) u16 (.clk(clk), .rst(rst), .bus(b.slave));

  function automatic exp_t model(input logic [15:0] d, input int w);
    exp_t e;
    int   n;
    bit   found;
    e = '0;
    n = 0;
    found = 0;
    for (int i = w - 1; i >= 0; i--)
      if (!found) begin
        if (d[i]) found = 1;
        else n++;
      end
    if (!found) begin
      e.zero = 1'b1;
      return e;
    end
    e.data  = d << n;
    e.shamt = n[3:0];
    return e;
  endfunction

  task automatic cyc8(input logic v, input logic [7:0] d, input logic r,
                      output logic ifire, output logic ofire);
    exp_t e;
    @(negedge clk);
    a.in_valid = v; a.in_data = d; a.out_ready = r;
    #1;
    ifire = a.in_valid && a.in_ready;
    ofire = a.out_valid && a.out_ready;
    if (ifire) q8.push_back(model({8'h00, d}, 8));
    if (ofire) begin
      total++;
      if (q8.size() == 0) begin
        $display("FAIL out8_unexpected got %h/%0d/%b with empty scoreboard", a.out_data, a.out_shamt, a.out_zero);
      end else begin
        e = q8.pop_front();
        if ({a.out_data, a.out_shamt, a.out_zero} !== {e.data[7:0], e.shamt[2:0], e.zero})
          $display("FAIL out8 got %h/%0d/%b exp %h/%0d/%b", a.out_data, a.out_shamt, a.out_zero,
                   e.data[7:0], e.shamt[2:0], e.zero);
        else pass++;
      end
    end
  endtask

  task automatic cyc16(input logic v, input logic [15:0] d, input logic r,
                       output logic ifire, output logic ofire);
    exp_t e;
    @(negedge clk);
    b.in_valid = v; b.in_data = d; b.out_ready = r;
    #1;
    ifire = b.in_valid && b.in_ready;
    ofire = b.out_valid && b.out_ready;
    if (ifire) q16.push_back(model(d, 16));
    if (ofire) begin
      total++;
      if (q16.size() == 0) begin
        $display("FAIL out16_unexpected got %h/%0d/%b with empty scoreboard", b.out_data, b.out_shamt, b.out_zero);
      end else begin
        e = q16.pop_front();
        if ({b.out_data, b.out_shamt, b.out_zero} !== {e.data, e.shamt, e.zero})
          $display("FAIL out16 got %h/%0d/%b exp %h/%0d/%b", b.out_data, b.out_shamt, b.out_zero,
                   e.data, e.shamt, e.zero);
        else pass++;
      end
    end
  endtask

  task automatic drain8();
    logic i, o;
    for (int k = 0; k < 20 && q8.size() != 0; k++) cyc8(1'b0, 8'h00, 1'b1, i, o);
    total++;
    if (q8.size() != 0) $display("FAIL drain8 timeout pending=%0d required=0", q8.size());
    else pass++;
    cyc8(1'b0, 8'h00, 1'b1, i, o);
    total++;
    if (a.out_valid !== 1'b0) $display("FAIL drain8_idle out_valid=%b required=0", a.out_valid);
    else pass++;
  endtask

  task automatic drain16();
    logic i, o;
    for (int k = 0; k < 20 && q16.size() != 0; k++) cyc16(1'b0, 16'h0000, 1'b1, i, o);
    total++;
    if (q16.size() != 0) $display("FAIL drain16 timeout pending=%0d required=0", q16.size());
    else pass++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    a.in_valid = 1'b1; a.in_data = 8'hFF;   a.out_ready = 1'b1;
    b.in_valid = 1'b1; b.in_data = 16'h00F0; b.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    a.in_valid = 1'b0; b.in_valid = 1'b0;
    #1;
    total++; if (a.out_valid !== 1'b0) $display("FAIL rst_valid8 got %b required 0", a.out_valid); else pass++;
    total++; if (a.out_data !== 8'h00) $display("FAIL rst_data8 got %h required 00", a.out_data); else pass++;
    total++; if (a.out_shamt !== 3'd0) $display("FAIL rst_shamt8 got %0d required 0", a.out_shamt); else pass++;
    total++; if (a.out_zero !== 1'b0) $display("FAIL rst_zero8 got %b required 0", a.out_zero); else pass++;
    total++; if (a.in_ready !== 1'b1) $display("FAIL rst_ready8 got %b required 1", a.in_ready); else pass++;
    total++; if (b.out_valid !== 1'b0 || b.in_ready !== 1'b1)
      $display("FAIL rst_16 valid=%b ready=%b required 0/1", b.out_valid, b.in_ready); else pass++;
    // Words presented while rst was high must not show up.
    repeat (2) @(negedge clk);
    #1;
    total++; if (a.out_valid !== 1'b0) $display("FAIL rst_ignored8 out_valid=%b required 0", a.out_valid); else pass++;
  endtask

  task automatic test_basic();
    logic i, o;
    cyc8(1'b1, 8'h01, 1'b1, i, o);
    total++; if (i !== 1'b1) $display("FAIL basic_accept got %b required 1", i); else pass++;
    cyc8(1'b1, 8'h80, 1'b1, i, o);
    total++; if (a.out_valid !== 1'b0) $display("FAIL basic_latency_early out_valid=%b required 0", a.out_valid); else pass++;
    cyc8(1'b1, 8'h13, 1'b1, i, o);
    total++; if (a.out_valid !== 1'b1 || a.out_data !== 8'h80 || a.out_shamt !== 3'd7)
      $display("FAIL basic_first got %b/%h/%0d required 1/80/7", a.out_valid, a.out_data, a.out_shamt); else pass++;
    cyc8(1'b1, 8'h40, 1'b1, i, o);
    total++; if (a.out_data !== 8'h80 || a.out_shamt !== 3'd0)
      $display("FAIL basic_second got %h/%0d required 80/0", a.out_data, a.out_shamt); else pass++;
    cyc8(1'b0, 8'h00, 1'b1, i, o);
    total++; if (a.out_data !== 8'h98 || a.out_shamt !== 3'd3)
      $display("FAIL basic_third got %h/%0d required 98/3", a.out_data, a.out_shamt); else pass++;
    cyc8(1'b0, 8'h00, 1'b1, i, o);
    total++; if (a.out_data !== 8'h80 || a.out_shamt !== 3'd1 || a.out_valid !== 1'b1)
      $display("FAIL basic_fourth got %b/%h/%0d required 1/80/1", a.out_valid, a.out_data, a.out_shamt); else pass++;
    drain8();
  endtask

  task automatic test_zero();
    logic i, o;
    cyc8(1'b1, 8'h00, 1'b1, i, o);
    cyc8(1'b0, 8'h00, 1'b1, i, o);
    cyc8(1'b0, 8'h00, 1'b1, i, o);
    total++; if ({a.out_valid, a.out_data, a.out_shamt, a.out_zero} !== {1'b1, 8'h00, 3'd0, 1'b1})
      $display("FAIL zero got %b/%h/%0d/%b required 1/00/0/1", a.out_valid, a.out_data, a.out_shamt, a.out_zero);
    else pass++;
    drain8();
  endtask

  task automatic test_backpressure();
    logic i, o;
    int   acc = 0;
    cyc8(1'b1, 8'h01, 1'b0, i, o); acc += int'(i);
    cyc8(1'b1, 8'h02, 1'b0, i, o); acc += int'(i);
    for (int k = 0; k < 3; k++) begin
      cyc8(1'b1, 8'h03, 1'b0, i, o); acc += int'(i);
      total++; if (a.in_ready !== 1'b0) $display("FAIL bp_ready cycle %0d got %b required 0", k, a.in_ready); else pass++;
      total++; if (a.out_valid !== 1'b1 || a.out_data !== 8'h80 || a.out_shamt !== 3'd7)
        $display("FAIL bp_hold cycle %0d got %b/%h/%0d required 1/80/7", k, a.out_valid, a.out_data, a.out_shamt);
      else pass++;
    end
    total++; if (acc != 2) $display("FAIL bp_accepts got %0d required 2", acc); else pass++;
    cyc8(1'b1, 8'h03, 1'b1, i, o);
    cyc8(1'b0, 8'h00, 1'b1, i, o);
    drain8();
  endtask

  task automatic test_full_simul();
    logic i, o;
    cyc8(1'b1, 8'h55, 1'b0, i, o);
    cyc8(1'b1, 8'h0F, 1'b0, i, o);
    cyc8(1'b1, 8'h2A, 1'b1, i, o);
    total++; if (i !== 1'b1 || o !== 1'b1) $display("FAIL full_simul in_fire=%b out_fire=%b required 1/1", i, o); else pass++;
    cyc8(1'b0, 8'h00, 1'b0, i, o);
    total++; if (a.out_valid !== 1'b1 || a.in_ready !== 1'b0)
      $display("FAIL full_occupancy out_valid=%b in_ready=%b required 1/0", a.out_valid, a.in_ready); else pass++;
    drain8();
  endtask

  task automatic test_reset_mid();
    logic i, o;
    cyc8(1'b1, 8'h21, 1'b0, i, o);
    cyc8(1'b1, 8'h07, 1'b0, i, o);
    @(negedge clk);
    rst = 1'b1; a.in_valid = 1'b1; a.in_data = 8'h33; a.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0; a.in_valid = 1'b0;
    q8.delete();
    #1;
    total++; if ({a.out_valid, a.out_data, a.out_shamt, a.out_zero} !== 13'd0)
      $display("FAIL midrst_out got %b/%h/%0d/%b required all 0", a.out_valid, a.out_data, a.out_shamt, a.out_zero);
    else pass++;
    total++; if (a.in_ready !== 1'b1) $display("FAIL midrst_ready got %b required 1", a.in_ready); else pass++;
    cyc8(1'b1, 8'h01, 1'b1, i, o);
    cyc8(1'b0, 8'h00, 1'b1, i, o);
    total++; if (o !== 1'b0) $display("FAIL midrst_early out_fire=%b required 0", o); else pass++;
    cyc8(1'b0, 8'h00, 1'b1, i, o);
    total++; if (o !== 1'b1 || a.out_data !== 8'h80 || a.out_shamt !== 3'd7)
      $display("FAIL midrst_word fire=%b got %h/%0d required 1/80/7", o, a.out_data, a.out_shamt); else pass++;
    drain8();
  endtask

  task automatic test_random8();
    logic i, o;
    int   sent = 0;
    for (int c = 0; c < 20000 && sent < 1000; c++) begin
      cyc8(1'($urandom_range(0, 1)), 8'($urandom) >> $urandom_range(0, 8), 1'($urandom_range(0, 3) != 0), i, o);
      if (i) sent++;
    end
    total++; if (sent != 1000) $display("FAIL rand8_sent got %0d required 1000", sent); else pass++;
    drain8();
  endtask

  task automatic test_random16();
    logic i, o;
    int   sent = 0;
    for (int c = 0; c < 20000 && sent < 1000; c++) begin
      cyc16(1'($urandom_range(0, 1)), 16'($urandom) >> $urandom_range(0, 16), 1'($urandom_range(0, 3) != 0), i, o);
      if (i) sent++;
    end
    total++; if (sent != 1000) $display("FAIL rand16_sent got %0d required 1000", sent); else pass++;
    drain16();
  endtask

  initial begin
    a.in_valid = 1'b0; a.in_data = '0; a.out_ready = 1'b0;
    b.in_valid = 1'b0; b.in_data = '0; b.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_full_simul();
    test_reset_mid();
    test_random8();
    test_random16();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
